wmux: RTL
=========

WMUX -- requirements
Module: wmux

Interface
REQ-001 SHALL have parameters: DW, 8, lane width; DN, 8, lane count; DW1, 16, SDRAM pixel width; IFW, 4, info width; AW, 14, address width.
REQ-002 SHALL have clk  in  1  single clock, rising edge.
REQ-003 SHALL have rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have info  in  IFW  [3] = destination (0 RAM, 1 SDRAM), [2:0] = channel count (0 means all DN).
REQ-005 SHALL have m_data, m_data_first, m_data_last, m_data_valid  in  DN*DW,1,1,1  result beat stream; m_data_ready  out  1.
REQ-006 SHALL have m_addr, m_addr_first, m_addr_last, m_addr_valid  in  AW,1,1,1  write-address stream; m_addr_ready  out  1.
REQ-007 SHALL have s_waddr0, s_wdata0, s_wfirst0, s_wlast0, s_wvalid0  out  AW,DN*DW,1,1,1  RAM write channel; s_wready0  in  1.
REQ-008 SHALL have s_waddr1, s_wdata1, s_wfirst1, s_wlast1, s_wvalid1  out  AW,DW1,1,1,1  SDRAM write channel; s_wready1  in  1.
REQ-009 SHALL have busy  out  1  frame in progress; err_sync  out  1  sticky protocol error; err_clr  in  1  clears err_sync.

Function
REQ-010 SHALL join streams: a beat is accepted only when m_addr_valid and m_data_valid are both high and the selected output register is empty or draining in the same cycle; m_addr_ready and m_data_ready are driven identically.
REQ-011 SHALL NOT let m_*_ready depend combinationally on m_*_valid.
REQ-012 SHALL latch info into a frame register on the accepted beat that starts a frame; info changes mid-frame are ignored.
REQ-013 SHALL implement FSM IDLE -> BURST on an accepted beat without last; BURST -> IDLE on an accepted beat with last; IDLE -> IDLE on a beat with first and last (single-beat frame); busy = (state == BURST).
REQ-014 SHALL zero lane i of the data when i >= channel count (channel 0 enables all lanes), before routing.
REQ-015 SHALL route RAM beats as {masked data, addr, first, last} to a one-entry output register; latency one cycle from acceptance to s_wvalid0.
REQ-016 SHALL pack SDRAM beats as s_wdata1 = {d[23:19], d[15:10], d[7:3]} (RGB565), lanes 3..DN-1 discarded, into a separate one-entry register with one-cycle latency.
REQ-017 SHALL hold output register contents stable while s_wvalid is high and s_wready is low; it reloads in the cycle s_wready is high, sustaining one beat per cycle.
REQ-018 SHALL use the data stream's first/last as authoritative; an addr/data first or last mismatch sets err_sync.
REQ-019 SHALL, on a beat without first in IDLE, start a frame anyway and set err_sync.
REQ-020 SHALL, on a beat with first in BURST, restart the frame (relatch info) and set err_sync.
REQ-021 SHALL let err_clr clear err_sync, with a same-cycle error taking priority over the clear.

Reset
REQ-022 SHALL, on rst, asynchronously force state IDLE, s_wvalid0 = s_wvalid1 = 0, all output data/addr/first/last = 0, frame register = 0, busy = 0, err_sync = 0; m_*_ready = 0 while rst is high.
REQ-023 SHALL discard any beat held in an output register when reset is asserted mid-frame; the first beat after reset starts a new frame.

Configuration
REQ-024 SHALL, with WMUX_ROUND_EN defined, round each SDRAM colour field to nearest (add half-LSB of the truncated bits, saturating at the field maximum) before packing; without it, plain truncation per REQ-016.

Verification
REQ-025 SHALL cover: info=4'b0000, 3-beat frame, data 64'h0102030405060708, addr 0x10..0x12, s_wready0=1 -> s_wvalid0 three consecutive cycles, latency 1, first on beat 0, last on beat 2.
REQ-026 SHALL cover: info=4'b1000, data lanes R=0xFF@[23:16], G=0x80@[15:8], B=0x07@[7:0] -> s_wdata1=16'hFC00 (truncated); with WMUX_ROUND_EN -> 16'hFC01.
REQ-027 SHALL cover: info=4'b0011, data 64'hFFFF_FFFF_FFFF_FFFF -> s_wdata0 = 64'h0000_0000_00FF_FFFF.
REQ-028 SHALL cover: s_wready0 held low 4 cycles mid-frame -> s_wdata0 stable, m_data_ready low after register fills, no beat lost or duplicated.
REQ-029 SHALL cover: first asserted on beat 2 of a burst, then info switched to 4'b1000 mid-frame -> err_sync=1, new frame routed per info latched at beat 2; err_clr pulse -> err_sync=0.
REQ-030 SHALL cover: rst pulsed while s_wvalid1=1 in BURST -> next cycle s_wvalid1=0, busy=0; a subsequent first-beat frame completes normally.

Source files
------------

// File: rtl/wmux_if.sv
// Bus bundle for wmux: joined result-beat/address input streams, RAM and SDRAM
// write channels, and frame status. wmux takes the slave view, the stream source the master view.
interface wmux_if #(
    parameter int DW  = 8,
    parameter int DN  = 8,
    parameter int DW1 = 16,
    parameter int IFW = 4,
    parameter int AW  = 14
);
    logic [IFW-1:0]   info;

    logic [DN*DW-1:0] m_data;
    logic             m_data_first;
    logic             m_data_last;
    logic             m_data_valid;
    logic             m_data_ready;

    logic [AW-1:0]    m_addr;
    logic             m_addr_first;
    logic             m_addr_last;
    logic             m_addr_valid;
    logic             m_addr_ready;

    logic [AW-1:0]    s_waddr0;
    logic [DN*DW-1:0] s_wdata0;
    logic             s_wfirst0;
    logic             s_wlast0;
    logic             s_wvalid0;
    logic             s_wready0;

    logic [AW-1:0]    s_waddr1;
    logic [DW1-1:0]   s_wdata1;
    logic             s_wfirst1;
    logic             s_wlast1;
    logic             s_wvalid1;
    logic             s_wready1;

    logic             busy;
    logic             err_sync;
    logic             err_clr;

    modport slave (
        input  info,
        input  m_data, m_data_first, m_data_last, m_data_valid,
        output m_data_ready,
        input  m_addr, m_addr_first, m_addr_last, m_addr_valid,
        output m_addr_ready,
        output s_waddr0, s_wdata0, s_wfirst0, s_wlast0, s_wvalid0,
        input  s_wready0,
        output s_waddr1, s_wdata1, s_wfirst1, s_wlast1, s_wvalid1,
        input  s_wready1,
        output busy, err_sync,
        input  err_clr
    );

    modport master (
        output info,
        output m_data, m_data_first, m_data_last, m_data_valid,
        input  m_data_ready,
        output m_addr, m_addr_first, m_addr_last, m_addr_valid,
        input  m_addr_ready,
        input  s_waddr0, s_wdata0, s_wfirst0, s_wlast0, s_wvalid0,
        output s_wready0,
        input  s_waddr1, s_wdata1, s_wfirst1, s_wlast1, s_wvalid1,
        output s_wready1,
        input  busy, err_sync,
        output err_clr
    );
endinterface

// File: rtl/wmux.sv
// wmux: joins the result-beat and write-address streams and routes each beat to the RAM
// channel or, packed as RGB565, the SDRAM channel. Define WMUX_ROUND_EN to round colour fields.
module wmux #(
    parameter int DW  = 8,
    parameter int DN  = 8,
    parameter int DW1 = 16,
    parameter int IFW = 4,
    parameter int AW  = 14
) (
    input  logic  clk,
    input  logic  rst,
    wmux_if.slave bus
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] BURST = 1'b1;

`ifdef WMUX_ROUND_EN
    localparam logic ROUND = 1'b1;
`else
    localparam logic ROUND = 1'b0;
`endif

    logic [0:0]       state_q, state_d;
    logic [IFW-1:0]   frame_q, frame_d;
    logic             err_q, err_d;

    logic [AW-1:0]    waddr0_q;
    logic [DN*DW-1:0] wdata0_q;
    logic             wfirst0_q, wlast0_q, wvalid0_q;
    logic [AW-1:0]    waddr1_q;
    logic [DW1-1:0]   wdata1_q;
    logic             wfirst1_q, wlast1_q, wvalid1_q;

    logic             start, dest, ready, accept, err_set;
    logic [IFW-1:0]   cur_info;
    logic [2:0]       chans;
    logic [DN*DW-1:0] masked;
    logic [15:0]      pix565;

    // Argument is the kept field with the next-lower bit appended as the rounding bit.
    function automatic logic [4:0] fit5(input logic [5:0] x);
        logic [5:0] s;
        s = {1'b0, x[5:1]} + {5'd0, ROUND & x[0]};
        fit5 = s[5] ? 5'h1F : s[4:0];
    endfunction

    function automatic logic [5:0] fit6(input logic [6:0] x);
        logic [6:0] s;
        s = {1'b0, x[6:1]} + {6'd0, ROUND & x[0]};
        fit6 = s[6] ? 6'h3F : s[5:0];
    endfunction

    always_comb begin
        start    = (state_q == IDLE) || bus.m_data_first;
        cur_info = start ? bus.info : frame_q;
        dest     = cur_info[3];
        chans    = cur_info[2:0];
        // Ready looks only at the chosen output register, never at the input valids.
        ready    = !rst && (dest ? (!wvalid1_q || bus.s_wready1)
                                 : (!wvalid0_q || bus.s_wready0));
        accept   = ready && bus.m_addr_valid && bus.m_data_valid;

        masked = '0;
        for (int i = 0; i < DN; i++) begin
            if (chans == 3'd0 || i < int'(chans))
                masked[i*DW +: DW] = bus.m_data[i*DW +: DW];
        end
        pix565 = {fit5(masked[23:18]), fit6(masked[15:9]), fit5(masked[7:2])};

        err_set = accept && ((bus.m_addr_first != bus.m_data_first) ||
                             (bus.m_addr_last  != bus.m_data_last)  ||
                             (state_q == IDLE  && !bus.m_data_first) ||
                             (state_q == BURST &&  bus.m_data_first));
        err_d   = err_set ? 1'b1 : (bus.err_clr ? 1'b0 : err_q);

        state_d = state_q;
        frame_d = frame_q;
        if (accept) begin
            state_d = bus.m_data_last ? IDLE : BURST;
            if (start)
                frame_d = bus.info;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            frame_q   <= '0;
            err_q     <= 1'b0;
            waddr0_q  <= '0;
            wdata0_q  <= '0;
            wfirst0_q <= 1'b0;
            wlast0_q  <= 1'b0;
            wvalid0_q <= 1'b0;
            waddr1_q  <= '0;
            wdata1_q  <= '0;
            wfirst1_q <= 1'b0;
            wlast1_q  <= 1'b0;
            wvalid1_q <= 1'b0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            err_q   <= err_d;

            if (accept && !dest) begin
                waddr0_q  <= bus.m_addr;
                wdata0_q  <= masked;
                wfirst0_q <= bus.m_data_first;
                wlast0_q  <= bus.m_data_last;
                wvalid0_q <= 1'b1;
            end else if (bus.s_wready0) begin
                wvalid0_q <= 1'b0;
            end

            if (accept && dest) begin
                waddr1_q  <= bus.m_addr;
                wdata1_q  <= DW1'(pix565);
                wfirst1_q <= bus.m_data_first;
                wlast1_q  <= bus.m_data_last;
                wvalid1_q <= 1'b1;
            end else if (bus.s_wready1) begin
                wvalid1_q <= 1'b0;
            end
        end
    end

    assign bus.m_data_ready = ready;
    assign bus.m_addr_ready = ready;
    assign bus.s_waddr0     = waddr0_q;
    assign bus.s_wdata0     = wdata0_q;
    assign bus.s_wfirst0    = wfirst0_q;
    assign bus.s_wlast0     = wlast0_q;
    assign bus.s_wvalid0    = wvalid0_q;
    assign bus.s_waddr1     = waddr1_q;
    assign bus.s_wdata1     = wdata1_q;
    assign bus.s_wfirst1    = wfirst1_q;
    assign bus.s_wlast1     = wlast1_q;
    assign bus.s_wvalid1    = wvalid1_q;
    assign bus.busy         = (state_q == BURST);
    assign bus.err_sync     = err_q;
endmodule
